// File: rtl/zstd_header_writer.sv
// Zstandard frame header writer.
// Packs magic, FHD, optional WD, DID and FCS fields into an 18-byte buffer
// when start is accepted. It then streams the buffer two bytes per beat,
// little-endian, with valid/ready handshaking.
module zstd_header_writer #(
  parameter logic [31:0] MAGIC = 32'hFD2FB528
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        single_segment,
  input  logic        content_checksum,
  input  logic [1:0]  dict_id_flag,
  input  logic [1:0]  fcs_flag,
  input  logic [7:0]  window_descriptor,
  input  logic [31:0] dictionary_id,
  input  logic [63:0] frame_content_size,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] data_out,
  output logic [1:0]  byte_valid,
  output logic        busy,
  output logic        done,
  output logic [4:0]  header_bytes
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t         state, state_next;
  logic [143:0]   buffer;
  logic [4:0]     idx;
  logic           last_beat;

  logic [143:0]   hdr_next;
  logic [4:0]     len_next;
  logic [7:0]     fhd;
  logic [2:0]     did_len;
  logic [3:0]     fcs_len;
  logic [31:0]    did_val;
  logic [63:0]    fcs_val;
  logic [7:0]     off;

  // Assemble the header image; optional fields are OR-ed in at a running byte offset
  always_comb begin
    fhd = {fcs_flag, single_segment, 2'b00, content_checksum, dict_id_flag};

    unique case (dict_id_flag)
      2'd0:    begin did_len = 3'd0; did_val = '0; end
      2'd1:    begin did_len = 3'd1; did_val = {24'h0, dictionary_id[7:0]}; end
      2'd2:    begin did_len = 3'd2; did_val = {16'h0, dictionary_id[15:0]}; end
      default: begin did_len = 3'd4; did_val = dictionary_id; end
    endcase

    // 2-byte FCS carries a -256 bias; no range checking on the raw size
    unique case (fcs_flag)
      2'd0: begin
        fcs_len = single_segment ? 4'd1 : 4'd0;
        fcs_val = single_segment ? {56'h0, frame_content_size[7:0]} : '0;
      end
      2'd1:    begin fcs_len = 4'd2; fcs_val = {48'h0, frame_content_size[15:0] - 16'd256}; end
      2'd2:    begin fcs_len = 4'd4; fcs_val = {32'h0, frame_content_size[31:0]}; end
      default: begin fcs_len = 4'd8; fcs_val = frame_content_size; end
    endcase

    off      = 8'd40;
    hdr_next = {104'h0, fhd, MAGIC};
    if (!single_segment) begin
      hdr_next = hdr_next | ({136'h0, window_descriptor} << off);
      off      = off + 8'd8;
    end
    hdr_next = hdr_next | ({112'h0, did_val} << off);
    off      = off + {2'b00, did_len, 3'b000};
    hdr_next = hdr_next | ({80'h0, fcs_val} << off);

    len_next = 5'd5 + {4'b0, ~single_segment} + {2'b00, did_len} + {1'b0, fcs_len};
  end

  assign last_beat = ({1'b0, idx} + 6'd2) >= {1'b0, header_bytes};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Buffer, byte pointer and header length capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buffer       <= '0;
      idx          <= '0;
      header_bytes <= '0;
    end else if (state == IDLE && start) begin
      buffer       <= hdr_next;
      idx          <= '0;
      header_bytes <= len_next;
    end else if (state == EMIT && out_ready && !last_beat) begin
      idx <= idx + 5'd2;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = EMIT;
      EMIT:    if (out_ready && last_beat) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode; data is a pure function of state and pointer so it holds under stall
  always_comb begin
    out_valid  = (state == EMIT);
    busy       = (state == EMIT);
    done       = (state == DONE);
    data_out   = '0;
    byte_valid = '0;
    if (state == EMIT) begin
      if (({1'b0, idx} + 6'd1) == {1'b0, header_bytes}) begin
        data_out   = {8'h00, buffer[{idx, 3'b000} +: 8]};
        byte_valid = 2'b01;
      end else begin
        data_out   = buffer[{idx, 3'b000} +: 16];
        byte_valid = 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_zstd_header_writer.sv
// Self-checking bench for zstd_header_writer: directed test-plan cases plus
// randomized frames, each checked against a byte-queue header model and a
// loopback header parser.
module tb_zstd_header_writer;

  logic        clk = 1'b0;
  logic        reset, start, ss, chk, out_ready;
  logic [1:0]  didf, fcsf;
  logic [7:0]  wd;
  logic [31:0] did;
  logic [63:0] fcs;
  logic        out_valid, busy, done;
  logic [15:0] data_out;
  logic [1:0]  byte_valid;
  logic [4:0]  header_bytes;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  cap_q[$];

  zstd_header_writer #(.MAGIC(32'hFD2FB528)) dut (
    .clk(clk), .reset(reset), .start(start), .single_segment(ss),
    .content_checksum(chk), .dict_id_flag(didf), .fcs_flag(fcsf),
    .window_descriptor(wd), .dictionary_id(did), .frame_content_size(fcs),
    .out_ready(out_ready), .out_valid(out_valid), .data_out(data_out),
    .byte_valid(byte_valid), .busy(busy), .done(done), .header_bytes(header_bytes)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int unsigned did_size(input logic [1:0] f);
    return (f == 2'd3) ? 4 : int'(f);
  endfunction

  function automatic int unsigned fcs_size(input logic [1:0] f, input logic s);
    if (f == 2'd0) return s ? 1 : 0;
    return 1 << f;
  endfunction

  // Reference header: byte list built field by field
  task automatic build_model(input logic s, input logic c, input logic [1:0] df, input logic [1:0] ff,
                             input logic [7:0] w, input logic [31:0] d, input logic [63:0] f);
    logic [63:0] v;
    exp_q = '{8'h28, 8'hB5, 8'h2F, 8'hFD};
    exp_q.push_back({ff, s, 1'b0, 1'b0, c, df});
    if (!s) exp_q.push_back(w);
    for (int i = 0; i < int'(did_size(df)); i++) exp_q.push_back(8'((d >> (8 * i)) & 32'hFF));
    v = (ff == 2'd1) ? ((f - 64'd256) & 64'hFFFF) : f;
    for (int i = 0; i < int'(fcs_size(ff, s)); i++) exp_q.push_back(8'((v >> (8 * i)) & 64'hFF));
  endtask

  function automatic logic [7:0] cap_at(input int unsigned i);
    return (i < cap_q.size()) ? cap_q[i] : 8'h00;
  endfunction

  // Loopback parser over the captured stream; recovers fields and compares with what was sent
  task automatic parse_check(input logic s, input logic c, input logic [1:0] df, input logic [1:0] ff,
                             input logic [7:0] w, input logic [31:0] d, input logic [63:0] f);
    int unsigned p;
    logic [7:0]  hd;
    logic [31:0] rd;
    logic [63:0] rf, ef;
    check("lb_magic", {cap_at(3), cap_at(2), cap_at(1), cap_at(0)}, 64'hFD2FB528);
    hd = cap_at(4);
    check("lb_ss", hd[5], s);
    check("lb_chk", hd[2], c);
    check("lb_didf", hd[1:0], df);
    check("lb_fcsf", hd[7:6], ff);
    check("lb_resv", hd[4:3], 2'b00);
    p = 5;
    if (!hd[5]) begin
      check("lb_wd", cap_at(p), w);
      p++;
    end
    rd = '0;
    for (int i = 0; i < int'(did_size(hd[1:0])); i++) rd = rd | (32'(cap_at(p + i)) << (8 * i));
    p += did_size(hd[1:0]);
    check("lb_did", rd, (df == 2'd0) ? 32'h0 : (df == 2'd1) ? (d & 32'hFF) : (df == 2'd2) ? (d & 32'hFFFF) : d);
    rf = '0;
    for (int i = 0; i < int'(fcs_size(hd[7:6], hd[5])); i++) rf = rf | (64'(cap_at(p + i)) << (8 * i));
    p += fcs_size(hd[7:6], hd[5]);
    case (ff)
      2'd0:    ef = s ? (f & 64'hFF) : 64'h0;
      2'd1:    ef = (f - 64'd256) & 64'hFFFF;
      2'd2:    ef = f & 64'hFFFF_FFFF;
      default: ef = f;
    endcase
    check("lb_fcs", rf, ef);
    check("lb_len", cap_q.size(), p);
  endtask

  task automatic run_frame(input logic s, input logic c, input logic [1:0] df, input logic [1:0] ff,
                           input logic [7:0] w, input logic [31:0] d, input logic [63:0] f,
                           input int stall_beat, input int stall_n, input bit inject);
    int unsigned nb, beat, cyc;
    int stalls;
    logic [15:0] ed;
    logic [1:0]  eb;
    build_model(s, c, df, ff, w, d, f);
    cap_q.delete();
    nb = (exp_q.size() + 1) / 2;
    @(negedge clk);
    {ss, chk, didf, fcsf, wd, did, fcs} = {s, c, df, ff, w, d, f};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    {ss, chk, didf, fcsf, wd, did} = {$urandom, $urandom};
    fcs = {$urandom, $urandom};
    check("header_bytes", header_bytes, exp_q.size());
    beat = 0; cyc = 0; stalls = 0;
    while (beat < nb && cyc < 200) begin
      ed = {(2 * beat + 1 < exp_q.size()) ? exp_q[2 * beat + 1] : 8'h00, exp_q[2 * beat]};
      eb = (2 * beat + 1 < exp_q.size()) ? 2'b11 : 2'b01;
      check("out_valid", out_valid, 1'b1);
      check("busy", busy, 1'b1);
      check("done_early", done, 1'b0);
      check($sformatf("beat%0d_data", beat), data_out, ed);
      check($sformatf("beat%0d_bv", beat), byte_valid, eb);
      if (int'(beat) == stall_beat && stalls < stall_n) begin
        out_ready = 1'b0;
        stalls++;
        start = inject && stalls == 1;
      end else begin
        out_ready = 1'b1;
        start = 1'b0;
        if (out_valid === 1'b1) begin
          cap_q.push_back(data_out[7:0]);
          if (byte_valid[1]) cap_q.push_back(data_out[15:8]);
          beat++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("beats_transferred", beat, nb);
    check("done_pulse", done, 1'b1);
    check("busy_done", busy, 1'b0);
    check("valid_done", out_valid, 1'b0);
    check("data_idle", {byte_valid, data_out}, 18'h0);
    out_ready = 1'($urandom);
    @(negedge clk);
    check("done_once", done, 1'b0);
    check("valid_idle", out_valid, 1'b0);
    check("header_bytes_hold", header_bytes, exp_q.size());
    parse_check(s, c, df, ff, w, d, f);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    ss = 1'b0; chk = 1'b0; didf = '0; fcsf = '0; wd = '0; did = '0; fcs = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_outputs", {out_valid, data_out, byte_valid, busy, done, header_bytes}, 26'h0);
    reset = 1'b0;

    // Test-plan cases 1-4
    run_frame(1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 32'h0, 64'h55, -1, 0, 1'b0);
    run_frame(1'b0, 1'b0, 2'd2, 2'd1, 8'h58, 32'hBEEF, 64'h1234, -1, 0, 1'b0);
    run_frame(1'b0, 1'b1, 2'd3, 2'd3, 8'h00, 32'h11223344, 64'h0102030405060708, -1, 0, 1'b0);
    run_frame(1'b0, 1'b0, 2'd1, 2'd0, 8'h60, 32'hAA, 64'h0, -1, 0, 1'b0);
    // Case 2 stalled on beat 3 for 3 cycles, with a stray start during EMIT
    run_frame(1'b0, 1'b0, 2'd2, 2'd1, 8'h58, 32'hBEEF, 64'h1234, 2, 3, 1'b1);

    // Reset while beat 2 is presented
    @(negedge clk);
    {ss, chk, didf, fcsf, wd, did, fcs} = {1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 32'h0, 64'h55};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("pre_rst_beat2", data_out, 16'hFD2F);
    reset = 1'b1;
    #1;
    check("async_rst_outputs", {out_valid, data_out, byte_valid, busy, done, header_bytes}, 26'h0);
    @(negedge clk);
    reset = 1'b0;
    check("rst_still_idle", out_valid, 1'b0);
    run_frame(1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 32'h0, 64'h55, -1, 0, 1'b0);

    // Randomized frames with random stalls
    for (int n = 0; n < 40; n++) begin
      run_frame(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 8'($urandom),
                $urandom, {$urandom, $urandom}, int'($urandom_range(0, 8)),
                int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
